// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared state encoding, default parameters and sizing helpers for the RO PUF engine
package ro_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_CMP,
        ST_OUT
    } ro_puf_state_e;

    localparam int DEF_NUM_RO  = 128;
    localparam int DEF_CNT_W   = 20;
    localparam int DEF_WINDOW  = 50000;
    localparam int DEF_SETTLE  = 4;
    localparam int DEF_REPEATS = 5;

    function automatic int vote_w(input int repeats);
        return $clog2(repeats + 1);
    endfunction

endpackage

// File: rtl/ro_puf_eval_if.sv
// ro_puf_eval_if: control and response handshake between the PUF engine and its consumer
interface ro_puf_eval_if
    import ro_puf_pkg::*;
#(
    parameter int PAIRS = DEF_NUM_RO / 2
);
    logic             start;
    logic             busy;
    logic             resp_valid;
    logic             resp_ready;
    logic [PAIRS-1:0] resp;

    modport master (input start, resp_ready, output busy, resp_valid, resp);
    modport slave  (output start, resp_ready, input busy, resp_valid, resp);
endinterface

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: synchronises one raw RO output and counts its rising edges with saturation
module ro_edge_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clk_ref,
    input  logic             rst,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    logic [2:0] sync;
    logic       rise;
    logic       sat;

    assign rise = sync[1] & ~sync[2];
    assign sat  = &cnt;

    // two synchroniser flops followed by one history flop for edge detection
    always_ff @(posedge clk_ref)
        sync <= rst ? 3'b000 : {sync[1:0], ro};

    // counter sticks at all-ones rather than wrapping
    always_ff @(posedge clk_ref)
        if (rst || clr) cnt <= '0;
        else if (en && rise && !sat) cnt <= cnt + 1'b1;
endmodule

// File: rtl/ro_puf_eval.sv
// ro_puf_eval: time-multiplexed RO PUF pair evaluator; RO_PUF_VOTE_EN adds per-pair majority voting
module ro_puf_eval
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO  = DEF_NUM_RO,
    parameter int PAIRS   = NUM_RO / 2,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int WINDOW  = DEF_WINDOW,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int REPEATS = DEF_REPEATS
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic [NUM_RO-1:0] ro_in,
    ro_puf_eval_if.master     bus
);
`ifdef RO_PUF_VOTE_EN
    localparam int REPS = REPEATS;
`else
    localparam int REPS = 1 + 0 * REPEATS;
`endif
    localparam int IW   = $clog2(NUM_RO);
    localparam int PW   = PAIRS > 1 ? $clog2(PAIRS) : 1;
    localparam int RW   = REPS > 1 ? $clog2(REPS) : 1;
    localparam int TMAX = WINDOW > SETTLE ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX);

    ro_puf_state_e    state;
    ro_puf_state_e    state_nxt;
    logic [PW-1:0]    pair;
    logic [RW-1:0]    rep;
    logic [TW-1:0]    tmr;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [IW-1:0]    sel_a;
    logic [IW-1:0]    sel_b;
    logic             clr;
    logic             en;
    logic             last_t;
    logic             last_pair;
    logic             last_rep;
    logic             done;
    logic             bit_ab;
    logic             busy;
    logic             resp_valid;
    logic [PAIRS-1:0] resp;

    assign sel_a     = IW'(pair);
    assign sel_b     = IW'(pair) + IW'(PAIRS);
    assign last_t    = tmr == (state == ST_SETTLE ? TW'(SETTLE - 1) : TW'(WINDOW - 1));
    assign last_pair = pair == PW'(PAIRS - 1);
    assign last_rep  = rep == RW'(REPS - 1);
    assign done      = last_pair && last_rep;
    assign bit_ab    = cnt_a > cnt_b;

    assign bus.busy       = busy;
    assign bus.resp_valid = resp_valid;
    assign bus.resp       = resp;

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk_ref (clk_ref),
        .rst     (rst),
        .ro      (ro_in[sel_a]),
        .clr     (clr),
        .en      (en),
        .cnt     (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk_ref (clk_ref),
        .rst     (rst),
        .ro      (ro_in[sel_b]),
        .clr     (clr),
        .en      (en),
        .cnt     (cnt_b)
    );

    // state register
    always_ff @(posedge clk_ref)
        state <= rst ? ST_IDLE : state_nxt;

    // next-state: settle, count, compare for every pair of every repetition
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = bus.start ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: state_nxt = last_t ? ST_COUNT : ST_SETTLE;
            ST_COUNT:  state_nxt = last_t ? ST_CMP : ST_COUNT;
            ST_CMP:    state_nxt = done ? ST_OUT : ST_SETTLE;
            ST_OUT:    state_nxt = bus.resp_ready ? ST_IDLE : ST_OUT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs and counter controls
    always_comb begin
        busy       = state == ST_SETTLE || state == ST_COUNT || state == ST_CMP;
        resp_valid = state == ST_OUT;
        clr        = state == ST_SETTLE;
        en         = state == ST_COUNT;
    end

    // pair/rep loop indices and a phase timer restarted on every state change
    always_ff @(posedge clk_ref) begin
        if (rst || state == ST_IDLE) begin
            pair <= '0;
            rep  <= '0;
        end else if (state == ST_CMP) begin
            pair <= last_pair ? '0 : pair + 1'b1;
            rep  <= last_pair ? rep + 1'b1 : rep;
        end
        tmr <= (rst || state_nxt != state) ? '0 : tmr + 1'b1;
    end

`ifdef RO_PUF_VOTE_EN
    localparam int VW = vote_w(REPS);

    logic [VW-1:0]    vote [PAIRS];
    logic [PAIRS-1:0] maj;

    // majority per pair, folding in the compare being made this cycle
    always_comb
        for (int p = 0; p < PAIRS; p++)
            maj[p] = (vote[p] + VW'(bit_ab && pair == PW'(p))) > VW'(REPS / 2);

    // vote bank cleared when an evaluation starts, bumped on each winning compare
    always_ff @(posedge clk_ref)
        if (rst || (state == ST_IDLE && bus.start)) vote <= '{default: '0};
        else if (state == ST_CMP && bit_ab) vote[pair] <= vote[pair] + 1'b1;

    // response only changes when the final compare completes the vote
    always_ff @(posedge clk_ref)
        if (rst) resp <= '0;
        else if (state == ST_CMP && done) resp <= maj;
`else
    // each compare writes its response bit directly
    always_ff @(posedge clk_ref)
        if (rst) resp <= '0;
        else if (state == ST_CMP) resp[pair] <= bit_ab;
`endif
endmodule
